// File: rtl/dmem_map_pkg.sv
// Address map, status-register layout and data width shared by the
// data-memory MMIO responder and its sub-blocks.
package dmem_map_pkg;

  localparam int DATA_W = 32;

  localparam logic [11:0] ADDR_FIFO_DATA   = 12'hFF0;
  localparam logic [11:0] ADDR_FIFO_STATUS = 12'hFF1;
  localparam logic [11:0] ADDR_CYCLE       = 12'hFF2;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and no fall-through.
// A push while full is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Head reads as zero when empty so the output is clean after reset.
    rdata = empty ? '0 : mem[rd_ptr_q];
    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM, output FIFO, FIFO status and cycle counter.
// Build option CYCLE_COUNTER_EN adds the CYCLE register at 0xFF2.
module dmem_mmio_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow
);

  // out_valid/out_ready: a word leaves on any edge where both are high;
  // out_data holds the same head word while out_valid && !out_ready.

  logic [DATA_W-1:0]         ram [2**RAM_AW];
  logic [RAM_AW-1:0]         ram_idx;
  logic                      in_ram;
  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [DATA_W-1:0]         status_word, cycle_rd;
  logic [DATA_W-1:0]         q_dmem_q, q_dmem_d;
  logic                      ovf_q, ovf_d;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef CYCLE_COUNTER_EN
  logic [DATA_W-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d    = (wren && address_dmem == ADDR_CYCLE) ? data : cyc_q + DATA_W'(1);
    cycle_rd = cyc_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end
`else
  always_comb cycle_rd = '0;
`endif

  always_comb begin
    in_ram    = ((address_dmem >> RAM_AW) == '0);
    ram_idx   = address_dmem[RAM_AW-1:0];
    out_valid = !fifo_empty;
    fifo_push = wren && (address_dmem == ADDR_FIFO_DATA);
    fifo_pop  = out_valid && out_ready;

    status_word                       = '0;
    status_word[ST_EMPTY]             = fifo_empty;
    status_word[ST_FULL]              = fifo_full;
    status_word[ST_OVF]               = ovf_q;
    status_word[ST_COUNT_LSB +: 8]    = 8'(fifo_count);

    // All reads see pre-edge state, including RAM during a same-word write.
    if (in_ram)                                 q_dmem_d = ram[ram_idx];
    else if (address_dmem == ADDR_FIFO_STATUS)  q_dmem_d = status_word;
    else if (address_dmem == ADDR_CYCLE)        q_dmem_d = cycle_rd;
    else                                        q_dmem_d = '0;

    ovf_d = ovf_q;
    if (wren && address_dmem == ADDR_FIFO_STATUS) ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wren && in_ram) begin
      ram[ram_idx] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_dmem_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      q_dmem_q <= q_dmem_d;
      ovf_q    <= ovf_d;
    end
  end

  assign q_dmem   = q_dmem_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios then random traffic,
// every cycle compared with a queue/array reference model.
module tb_dmem_mmio_responder;

  localparam int DEPTH     = 8;
  localparam int RAM_WORDS = 1024;
`ifdef CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  // clock / reset
  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        overflow;

  always #5 clock = ~clock;

  dmem_mmio_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow     (overflow)
  );

  // reference model / scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] ram_m [RAM_WORDS];
  bit          ram_known [RAM_WORDS];
  bit          ovf_m;
  logic [31:0] cyc_m;
  logic [31:0] q_m;
  bit          q_known;
  bit          model_ready;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step(input logic [11:0] a, input logic [31:0] d, input logic we,
                            input logic rdy, input logic rst_n);
    int  ai;
    int  cnt;
    bit  in_ram, popped, dropped;
    ai     = int'(a);
    in_ram = (ai < RAM_WORDS);
    if (!rst_n) begin
      q_m = '0; q_known = 1'b1; exp_q.delete(); ovf_m = 1'b0; cyc_m = '0;
      model_ready = 1'b1;
    end else begin
      cnt     = exp_q.size();
      q_known = 1'b1;
      if (in_ram) begin
        q_m = ram_m[ai]; q_known = ram_known[ai];
      end else if (a == 12'hFF1)
        q_m = {16'h0, 8'(cnt), 5'b0, ovf_m, (cnt == DEPTH), (cnt == 0)};
      else if (a == 12'hFF2)
        q_m = CYC_EN ? cyc_m : 32'h0;
      else
        q_m = '0;
      popped  = rdy && (cnt > 0);
      dropped = 1'b0;
      if (popped) void'(exp_q.pop_front());
      if (we && a == 12'hFF0) begin
        if (cnt < DEPTH || popped) exp_q.push_back(d);
        else dropped = 1'b1;
      end
      if (we && a == 12'hFF1) ovf_m = 1'b0;
      if (dropped) ovf_m = 1'b1;
      cyc_m = (we && a == 12'hFF2) ? d : cyc_m + 32'd1;
    end
    if (we && in_ram) begin
      ram_m[ai] = d; ram_known[ai] = 1'b1;
    end
  endtask

  // driver tasks: present inputs for one edge, then compare #1 after it
  task automatic cycle_io(input logic [11:0] a, input logic [31:0] d, input logic we,
                          input logic rdy, input logic rst_n);
    address_dmem = a; data = d; wren = we; out_ready = rdy; reset = rst_n;
    model_step(a, d, we, rdy, rst_n);
    @(posedge clock);
    #1;
    if (model_ready) begin
      if (q_known) check("q_dmem", q_dmem, q_m);
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
      check("overflow", 32'(overflow), 32'(ovf_m));
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic rdy = 1'b0);
    cycle_io(a, d, 1'b1, rdy, 1'b1);
  endtask

  task automatic rd(input logic [11:0] a, input logic rdy = 1'b0);
    cycle_io(a, 32'h0, 1'b0, rdy, 1'b1);
  endtask

  initial begin
    logic [11:0] ra;
    address_dmem = '0; data = '0; wren = 1'b0; out_ready = 1'b0; reset = 1'b0;
    model_ready = 1'b0;
    for (int i = 0; i < RAM_WORDS; i++) ram_known[i] = 1'b0;

    cycle_io(12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle_io(12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_q_dmem", q_dmem, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);

    for (int i = 0; i < RAM_WORDS; i++) wr(12'(i), 32'h0);

    // RAM store/load
    wr(12'h005, 32'hDEADBEEF);
    rd(12'h005);
    check("ram_load", q_dmem, 32'hDEADBEEF);
    rd(12'h006);
    check("ram_zero", q_dmem, 32'h0);

    // read-during-write returns old word
    wr(12'h010, 32'h1);
    wr(12'h010, 32'h2);
    check("rdw_old", q_dmem, 32'h1);
    rd(12'h010);
    check("rdw_new", q_dmem, 32'h2);

    // fill past full with consumer stalled
    for (int i = 0; i < 8; i++) wr(12'hFF0, 32'h100 + 32'(i));
    rd(12'hFF1);
    check("status_full", q_dmem, 32'h0802);
    wr(12'hFF0, 32'h108);
    rd(12'hFF1);
    check("status_ovf", q_dmem, 32'h0806);
    check("ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", out_data, 32'h100 + 32'(i));
      rd(12'h800, 1'b1);
    end
    check("drain_empty", 32'(out_valid), 32'h0);

    // push and pop together while full
    wr(12'hFF1, 32'h0);
    check("ovf_clear", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) wr(12'hFF0, $urandom);
    wr(12'hFF0, 32'h55, 1'b1);
    rd(12'hFF1);
    check("full_pushpop_status", q_dmem, 32'h0802);
    for (int i = 0; i < 7; i++) rd(12'h800, 1'b1);
    check("pushpop_last", out_data, 32'h55);
    rd(12'h800, 1'b1);
    check("pushpop_empty", 32'(out_valid), 32'h0);

    // cycle counter load and wrap
    wr(12'hFF2, 32'hFFFFFFFE);
    rd(12'h800);
    rd(12'hFF2);
    check("cycle_pre_wrap", q_dmem, CYC_EN ? 32'hFFFFFFFF : 32'h0);
    rd(12'hFF2);
    check("cycle_wrap", q_dmem, 32'h0);

    // reset with entries queued and overflow set
    for (int i = 0; i < 9; i++) wr(12'hFF0, 32'h200 + 32'(i));
    for (int i = 0; i < 5; i++) rd(12'h800, 1'b1);
    rd(12'hFF1);
    check("pre_reset_status", q_dmem, 32'h0304);
    cycle_io(12'h800, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ovf", 32'(overflow), 32'h0);
    rd(12'hFF1);
    check("mid_rst_status", q_dmem, 32'h0001);
    rd(12'h005);
    check("mid_rst_ram", q_dmem, 32'hDEADBEEF);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: ra = 12'($urandom_range(0, 31));
        3:       ra = 12'($urandom_range(0, RAM_WORDS - 1));
        4, 5:    ra = 12'hFF0;
        6:       ra = 12'hFF1;
        default: ra = ($urandom_range(0, 1) == 0) ? 12'hFF2 : 12'($urandom_range(12'h400, 12'hFFF));
      endcase
      cycle_io(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 299) != 0));
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
